// File: rtl/sync_bank.sv
// sync_bank: NUM_CH-channel async-to-clk synchronizer with optional debounce, edge pulses and
// sticky event flags. Define SYNC_BANK_FILT_EN to compile in the per-channel debounce filter.
module sync_bank #(
    parameter int unsigned       NUM_CH    = 8,
    parameter int unsigned       SYNC_DLY  = 2,
    parameter logic [NUM_CH-1:0] RST_VAL   = '0,
    parameter int unsigned       EDGE_MODE = 1,
    parameter int unsigned       FILT_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [NUM_CH-1:0] data_in,
    input  logic [NUM_CH-1:0] sticky_clr,
    output logic [NUM_CH-1:0] data_synced,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] sticky,
    output logic              any_event
);

    if (SYNC_DLY < 2 || SYNC_DLY > 4) begin : g_bad_dly
        $error("sync_bank: SYNC_DLY=%0d outside 2..4", SYNC_DLY);
    end
    if (NUM_CH < 1 || NUM_CH > 64) begin : g_bad_ch
        $error("sync_bank: NUM_CH=%0d outside 1..64", NUM_CH);
    end
    if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt
        $error("sync_bank: FILT_CYC=%0d outside 1..255", FILT_CYC);
    end
    if (EDGE_MODE > 3) begin : g_bad_edge
        $error("sync_bank: EDGE_MODE=%0d outside 0..3", EDGE_MODE);
    end

    logic [NUM_CH-1:0] stage [SYNC_DLY];
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] prv;
    logic [NUM_CH-1:0] pulse;

    // Synchronizer chain: stage[0] is the metastability catcher
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < SYNC_DLY; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= data_in;
            for (int i = 1; i < SYNC_DLY; i++) stage[i] <= stage[i-1];
        end
    end

    assign s = stage[SYNC_DLY-1];

`ifdef SYNC_BANK_FILT_EN
    localparam logic [7:0] CNT_MAX = 8'(FILT_CYC - 1);

    logic [7:0] cnt [NUM_CH];

    // Debounce: lvl follows s only after s has disagreed for FILT_CYC consecutive cycles
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            lvl <= RST_VAL;
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (s[c] == lvl[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] == CNT_MAX) begin
                    lvl[c] <= s[c];
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + 8'd1;
                end
            end
        end
    end
`else
    assign lvl = s;
`endif

    assign data_synced = lvl;

    // Edge detect stage: prv trails lvl by one cycle
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) prv <= RST_VAL;
        else       prv <= lvl;
    end

    always_comb begin
        pulse = '0;
        case (EDGE_MODE)
            1:       pulse = lvl & ~prv;
            2:       pulse = ~lvl & prv;
            3:       pulse = lvl ^ prv;
            default: pulse = '0;
        endcase
    end

    assign pulse_out = pulse;
    assign any_event = |pulse;

    // Sticky stage: a pulse in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) sticky <= '0;
        else       sticky <= pulse | (sticky & ~sticky_clr);
    end

endmodule

// File: tb/tb_sync_bank.sv
// Directed bench for sync_bank: three instances (default, SYNC_DLY=3, any-edge) on shared inputs.
module tb_sync_bank;
`ifdef SYNC_BANK_FILT_EN
    localparam int FILT    = 4;
    localparam bit FILT_ON = 1'b1;
`else
    localparam int FILT    = 0;
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int LAT_A = 2 + FILT;
    localparam int LAT_B = 3 + FILT;

    logic       clk = 1'b0;
    logic       rst_;
    logic [7:0] data_in;
    logic [7:0] sticky_clr;
    logic [7:0] ds_a, pu_a, st_a, ds_b, pu_b, st_b, ds_c, pu_c, st_c;
    logic       any_a, any_b, any_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_bank #(.NUM_CH(8), .SYNC_DLY(2), .RST_VAL(8'h00), .EDGE_MODE(1), .FILT_CYC(4)) u_a (
        .clk(clk), .rst_(rst_), .data_in(data_in), .sticky_clr(sticky_clr),
        .data_synced(ds_a), .pulse_out(pu_a), .sticky(st_a), .any_event(any_a));

    sync_bank #(.NUM_CH(8), .SYNC_DLY(3), .RST_VAL(8'h00), .EDGE_MODE(1), .FILT_CYC(4)) u_b (
        .clk(clk), .rst_(rst_), .data_in(data_in), .sticky_clr(sticky_clr),
        .data_synced(ds_b), .pulse_out(pu_b), .sticky(st_b), .any_event(any_b));

    sync_bank #(.NUM_CH(8), .SYNC_DLY(2), .RST_VAL(8'h00), .EDGE_MODE(3), .FILT_CYC(4)) u_c (
        .clk(clk), .rst_(rst_), .data_in(data_in), .sticky_clr(sticky_clr),
        .data_synced(ds_c), .pulse_out(pu_c), .sticky(st_c), .any_event(any_c));

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_p;
        int last_p;
        int npulse;
        bit exp;

        // Reset with all inputs high
        rst_       = 1'b0;
        data_in    = 8'hFF;
        sticky_clr = 8'h00;
        repeat (3) tick();
        chk("rst_ds", ds_a, 8'h00);
        chk("rst_pulse", pu_a, 8'h00);
        chk("rst_sticky", st_a, 8'h00);
        chk("rst_any", 8'(any_a), 8'h00);
        chk("rst_ds_b", ds_b, 8'h00);
        rst_ = 1'b1;
        #1;
        chk("rel_ds", ds_a, 8'h00);
        chk("rel_pulse", pu_a, 8'h00);
        for (int i = 1; i <= LAT_A; i++) begin
            tick();
            chk("rel_ds_a", ds_a, (i == LAT_A) ? 8'hFF : 8'h00);
            chk("rel_pulse_a", pu_a, (i == LAT_A) ? 8'hFF : 8'h00);
        end
        chk("rel_any_a", 8'(any_a), 8'h01);
        tick();
        chk("rel_pulse_end", pu_a, 8'h00);
        chk("rel_sticky", st_a, 8'hFF);
        sticky_clr = 8'hFF;
        tick();
        chk("clr_all", st_a, 8'h00);
        sticky_clr = 8'h00;

        // Latency on channel 3, SYNC_DLY=3 instance
        data_in = 8'h00;
        repeat (12) tick();
        sticky_clr = 8'hFF;
        tick();
        sticky_clr = 8'h00;
        data_in = 8'h08;
        for (int i = 1; i <= LAT_B; i++) begin
            tick();
            chk("lat_ds_b", 8'(ds_b[3]), 8'(i >= LAT_B));
            chk("lat_pulse_b", pu_b, (i == LAT_B) ? 8'h08 : 8'h00);
            chk("lat_any_b", 8'(any_b), 8'(i == LAT_B));
            if (i == LAT_A) chk("lat_ds_a", ds_a, 8'h08);
        end
        tick();
        chk("lat_pulse_b_end", pu_b, 8'h00);
        chk("lat_sticky_b", st_b, 8'h08);

        // Sticky set wins over clear on channel 2
        data_in = 8'h0C;
        repeat (LAT_A) tick();
        chk("stk_pulse", pu_a, 8'h04);
        sticky_clr = 8'h04;
        tick();
        chk("stk_set_wins", st_a & 8'h04, 8'h04);
        tick();
        chk("stk_clr", st_a & 8'h04, 8'h00);
        sticky_clr = 8'h00;

        // Any-edge on channel 5, transitions 10 cycles apart
        repeat (12) tick();
        data_in = 8'h2C;
        npulse  = 0;
        first_p = 0;
        last_p  = 0;
        for (int i = 1; i <= LAT_A + 20; i++) begin
            if (i == 11) data_in = 8'h0C;
            tick();
            exp = (i == LAT_A) || (i == LAT_A + 10);
            chk("edge_pulse_c", pu_c, exp ? 8'h20 : 8'h00);
            chk("edge_any_c", 8'(any_c), 8'(exp));
            chk("edge_rise_a", 8'(pu_a[5]), 8'(i == LAT_A));
            if (pu_c[5]) begin
                if (npulse == 0) first_p = i;
                last_p = i;
                npulse++;
            end
        end
        chk("edge_count", 8'(npulse), 8'd2);
        chk("edge_gap", 8'(last_p - first_p), 8'd10);
        chk("edge_sticky_c", st_c & 8'h20, 8'h20);
        chk("edge_ds_c", ds_c, 8'h0C);

        // 3-cycle glitch on channel 0
        repeat (12) tick();
        data_in = 8'h0D;
        for (int i = 1; i <= LAT_A + 8; i++) begin
            if (i == 4) data_in = 8'h0C;
            tick();
            exp = !FILT_ON && (i >= 2) && (i <= 4);
            chk("glitch3_ds", 8'(ds_a[0]), 8'(exp));
            chk("glitch3_pulse", 8'(pu_a[0]), 8'(!FILT_ON && i == 2));
        end

        // 4-cycle pulse on channel 0
        repeat (12) tick();
        data_in = 8'h0D;
        for (int i = 1; i <= LAT_A + 10; i++) begin
            if (i == 5) data_in = 8'h0C;
            tick();
            chk("pulse4_ds", 8'(ds_a[0]), 8'((i >= LAT_A) && (i <= LAT_A + 3)));
            chk("pulse4_pulse", 8'(pu_a[0]), 8'(i == LAT_A));
        end

        // Async reset while channel 1 is mid-debounce
        repeat (12) tick();
        data_in = 8'h0E;
        repeat (4) tick();
        rst_ = 1'b0;
        #2;
        chk("arst_ds", ds_a, 8'h00);
        chk("arst_pulse", pu_a, 8'h00);
        chk("arst_sticky", st_a, 8'h00);
        chk("arst_any", 8'(any_a), 8'h00);
        data_in = 8'h00;
        #2;
        rst_ = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("arst_post_pulse", pu_a, 8'h00);
            chk("arst_post_ds", ds_a, 8'h00);
            chk("arst_post_any_c", 8'(any_c), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
